ingress_port_arbiter: RTL and testbench
=======================================

INGRESS_PORT_ARBITER -- requirements
Module: ingress_port_arbiter

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 64, is the datapath width in bits.
REQ-002 Parameter C_AXIS_LEN_DATA_WIDTH, default 16, is the packet-length sideband width.
REQ-003 Parameter C_AXIS_SPT_DATA_WIDTH, default 8, is the source-port sideband width.
REQ-004 Parameter NUM_PORTS, default 4, legal range 2..C_AXIS_SPT_DATA_WIDTH, is the number of ingress FIFOs.
REQ-005 Clock and reset SHALL be as follows: asclk is the clock; aresetn is a synchronous, active-low reset.
REQ-006 in_data, input, NUM_PORTS*C_AXIS_DATA_WIDTH: per-port FIFO head data; in_strb, input, NUM_PORTS*C_AXIS_DATA_WIDTH/8: per-port byte strobes; in_last, input, NUM_PORTS: per-port last flag.
REQ-007 in_empty, input, NUM_PORTS: data FIFO empty; in_user_empty, input, NUM_PORTS: length FIFO empty; in_len, input, NUM_PORTS*C_AXIS_LEN_DATA_WIDTH: length FIFO head.
REQ-008 in_rd_en, output, NUM_PORTS: data FIFO pop; in_user_rd_en, output, NUM_PORTS: length FIFO pop.
REQ-009 tx_data, tx_strb, tx_valid (1), tx_last (1), tx_len_data and tx_spt_data SHALL be outputs at the parameter widths, presenting the granted port's FIFO head to the parser.
REQ-010 fifo_empty, output, 1: merged empty; fifo_rd_en, input, 1: parser data pop; tx_user_rd_en, input, 1: parser length pop.
REQ-011 grant, output, NUM_PORTS: one-hot current owner; busy, output, 1: a packet transfer is in progress.

Function
REQ-012 FSM states: ARB_IDLE, ARB_XFER, ARB_GAP.
REQ-013 A port is eligible when both ~in_empty[i] and ~in_user_empty[i] hold.
REQ-014 In ARB_IDLE with any port eligible, the arbiter SHALL pick the first eligible port after last_grant (round-robin, wrapping NUM_PORTS-1 to 0), register it into grant, and move to ARB_XFER one cycle later.
REQ-015 In ARB_XFER, for granted port g, the arbiter SHALL drive:
  - fifo_empty = in_empty[g]
  - tx_valid = ~in_empty[g]
  - tx_data/tx_strb/tx_last/tx_len_data = port g head, combinationally
  - in_rd_en[g] = fifo_rd_en & ~in_empty[g]
  - in_user_rd_en[g] = tx_user_rd_en & ~in_user_empty[g]
REQ-016 tx_spt_data SHALL be one-hot with bit g set, zero-extended to C_AXIS_SPT_DATA_WIDTH.
REQ-017 The pop cycle in_rd_en[g] & in_last[g] SHALL move the FSM to ARB_GAP and update last_grant to g.
REQ-018 ARB_GAP lasts exactly one cycle, then returns to ARB_IDLE; the minimum inter-packet gap at the parser is therefore 2 cycles.
REQ-019 Outside ARB_XFER: fifo_empty=1, tx_valid=0, and all in_rd_en/in_user_rd_en=0; fifo_rd_en and tx_user_rd_en are ignored.
REQ-020 Grant SHALL never change mid-packet, even if higher-priority ports become eligible.
REQ-021 A fifo_rd_en while in_empty[g]=1 SHALL pop nothing and SHALL NOT end the packet.
REQ-022 busy = (state == ARB_XFER).

Reset
REQ-023 On reset:
  - state = ARB_IDLE
  - grant = 0, busy = 0
  - last_grant = NUM_PORTS-1 (port 0 wins first)
  - all pop outputs = 0, fifo_empty = 1, tx_valid = 0
  - counters = 0
REQ-024 Reset asserted mid-packet SHALL drop the grant immediately with no further pops; the partial packet remains in the FIFO.

Configuration
REQ-025 With macro ARB_PKT_CNT_EN defined, the block SHALL add output pkt_cnt (NUM_PORTS*32), one counter per port, incremented on each REQ-017 event and wrapping at 2^32.
REQ-026 Without ARB_PKT_CNT_EN, the pkt_cnt port and its logic SHALL be absent.

Structure
REQ-027 A shared package SHALL hold the state localparams (one-hot, 3 bits), the default widths, and the one-hot-to-index function.
REQ-028 A sub-module rr_pick SHALL implement the combinational round-robin selection: inputs are the request vector and last_grant; output is the one-hot pick.

Verification
REQ-029 Single packet: port 2 holds 3 beats with len=24 -> grant=0100 one cycle after eligibility, 3 pops, tx_spt_data=0x04, ARB_GAP, then idle.
REQ-030 All 4 ports hold 2 packets each -> service order 0,1,2,3,0,1,2,3, with a 2-cycle gap between packets.
REQ-031 Port 1 is granted and port 0 becomes eligible mid-packet -> port 1 finishes all beats before port 0 is granted.
REQ-032 Port 3's FIFO goes empty mid-packet for 5 cycles while fifo_rd_en is held at 1 -> no pops, fifo_empty=1, grant held; packet resumes afterwards.
REQ-033 aresetn pulsed low on beat 2 of 4 -> grant=0 the next cycle, no pops, and port 0 is granted first after reset.
REQ-034 ARB_PKT_CNT_EN defined and 5 packets sent on port 1 -> pkt_cnt[63:32]=5, all other counters 0.

Source files
------------

// File: rtl/ingress_port_arbiter_pkg.sv
// Shared definitions for the ingress port arbiter: FSM state encodings,
// default sideband widths and the one-hot to index helper.
package ingress_port_arbiter_pkg;

    localparam int C_DEF_DATA_WIDTH     = 64;
    localparam int C_DEF_LEN_DATA_WIDTH = 16;
    localparam int C_DEF_SPT_DATA_WIDTH = 8;
    localparam int C_DEF_NUM_PORTS      = 4;

    typedef logic [2:0] arb_state_t;

    // One-hot state encoding kept as plain constants for legacy tools.
    localparam logic [2:0] ARB_IDLE = 3'b001;
    localparam logic [2:0] ARB_XFER = 3'b010;
    localparam logic [2:0] ARB_GAP  = 3'b100;

    // Converts a one-hot vector (up to 32 bits) into its bit index.
    // An all-zero vector maps to index 0.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] onehot);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            idx = idx | (onehot[i] ? 5'(i) : 5'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ingress_port_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first requesting port
// strictly after last_grant_i, wrapping from the top port back to port 0.
module rr_pick
    import ingress_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = C_DEF_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] last_grant_i,
    output logic [NUM_PORTS-1:0] pick_o
);

    logic found_s;
    logic hit_s;

    // Scan the ports in rotated order starting after the previous owner.
    always_comb begin
        pick_o  = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                hit_s = last_grant_i[j] & ~found_s & req_i[(j + k) % NUM_PORTS];
                pick_o[(j + k) % NUM_PORTS] = pick_o[(j + k) % NUM_PORTS] | hit_s;
                found_s = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/ingress_port_arbiter.sv
// Ingress port arbiter: merges NUM_PORTS ingress FIFO pairs (data + length)
// into a single parser-facing stream, one whole packet at a time, with
// round-robin fairness and a fixed one-cycle gap after each packet.
// Optional feature: define ARB_PKT_CNT_EN to add per-port packet counters
// on output pkt_cnt.
module ingress_port_arbiter
    import ingress_port_arbiter_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH     = C_DEF_DATA_WIDTH,
    parameter int C_AXIS_LEN_DATA_WIDTH = C_DEF_LEN_DATA_WIDTH,
    parameter int C_AXIS_SPT_DATA_WIDTH = C_DEF_SPT_DATA_WIDTH,
    parameter int NUM_PORTS             = C_DEF_NUM_PORTS
) (
    input  logic                                   asclk,
    input  logic                                   aresetn,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] in_strb,
    input  logic [NUM_PORTS-1:0]                   in_last,
    input  logic [NUM_PORTS-1:0]                   in_empty,
    input  logic [NUM_PORTS-1:0]                   in_user_empty,
    input  logic [NUM_PORTS*C_AXIS_LEN_DATA_WIDTH-1:0] in_len,
    output logic [NUM_PORTS-1:0]                   in_rd_en,
    output logic [NUM_PORTS-1:0]                   in_user_rd_en,
    output logic [C_AXIS_DATA_WIDTH-1:0]           tx_data,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]         tx_strb,
    output logic                                   tx_valid,
    output logic                                   tx_last,
    output logic [C_AXIS_LEN_DATA_WIDTH-1:0]       tx_len_data,
    output logic [C_AXIS_SPT_DATA_WIDTH-1:0]       tx_spt_data,
    output logic                                   fifo_empty,
    input  logic                                   fifo_rd_en,
    input  logic                                   tx_user_rd_en,
    output logic [NUM_PORTS-1:0]                   grant,
    output logic                                   busy
`ifdef ARB_PKT_CNT_EN
    ,
    output logic [NUM_PORTS*32-1:0]                pkt_cnt
`endif
);

    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    // Port 0 must win the first arbitration after reset.
    localparam logic [NUM_PORTS-1:0] LAST_GRANT_RST = {1'b1, {(NUM_PORTS-1){1'b0}}};

    arb_state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]       grant_q, grant_d;
    logic [NUM_PORTS-1:0]       last_grant_q, last_grant_d;
    logic [NUM_PORTS-1:0]       elig_s;
    logic [NUM_PORTS-1:0]       pick_s;
    logic [NUM_PORTS-1:0]       pop_s;
    logic [IDX_W-1:0]           gidx_s;
    logic                       xfer_s;
    logic                       pkt_done_s;

    logic [C_AXIS_DATA_WIDTH-1:0]     data_arr_s [NUM_PORTS];
    logic [STRB_W-1:0]                strb_arr_s [NUM_PORTS];
    logic [C_AXIS_LEN_DATA_WIDTH-1:0] len_arr_s  [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign data_arr_s[p] = in_data[p*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        assign strb_arr_s[p] = in_strb[p*STRB_W +: STRB_W];
        assign len_arr_s[p]  = in_len[p*C_AXIS_LEN_DATA_WIDTH +: C_AXIS_LEN_DATA_WIDTH];
    end

    // A port may be granted only when both its data and length heads exist.
    assign elig_s = ~in_empty & ~in_user_empty;

    rr_pick #(
        .NUM_PORTS    (NUM_PORTS)
    ) u_rr_pick (
        .req_i        (elig_s),
        .last_grant_i (last_grant_q),
        .pick_o       (pick_s)
    );

    assign gidx_s = IDX_W'(onehot_to_idx(32'(grant_q)));
    // Reset low blocks pops in the same cycle, so a reset mid-packet
    // leaves the rest of the packet untouched in the FIFO.
    assign xfer_s     = (state_q == ARB_XFER) & aresetn;
    assign pop_s      = xfer_s ? (grant_q & ~in_empty & {NUM_PORTS{fifo_rd_en}}) : '0;
    assign pkt_done_s = |(pop_s & in_last);

    assign in_rd_en = pop_s;
    assign grant    = grant_q;
    assign busy     = (state_q == ARB_XFER);

    // Route the owner's FIFO heads to the parser while a transfer is open.
    always_comb begin
        in_user_rd_en = '0;
        fifo_empty    = 1'b1;
        tx_valid      = 1'b0;
        tx_data       = '0;
        tx_strb       = '0;
        tx_last       = 1'b0;
        tx_len_data   = '0;
        tx_spt_data   = '0;
        if (xfer_s) begin
            in_user_rd_en = grant_q & ~in_user_empty & {NUM_PORTS{tx_user_rd_en}};
            fifo_empty    = in_empty[gidx_s];
            tx_valid      = ~in_empty[gidx_s];
            tx_data       = data_arr_s[gidx_s];
            tx_strb       = strb_arr_s[gidx_s];
            tx_last       = in_last[gidx_s];
            tx_len_data   = len_arr_s[gidx_s];
            tx_spt_data   = C_AXIS_SPT_DATA_WIDTH'(grant_q);
        end else begin
            in_user_rd_en = '0;
            fifo_empty    = 1'b1;
        end
    end

    // Packet-level arbitration FSM: pick, hold the grant to the last pop, then gap.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (|elig_s) begin
                    state_d = ARB_XFER;
                    grant_d = pick_s;
                end else begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            ARB_XFER: begin
                if (pkt_done_s) begin
                    state_d      = ARB_GAP;
                    grant_d      = '0;
                    last_grant_d = grant_q;
                end else begin
                    state_d = ARB_XFER;
                    grant_d = grant_q;
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d      = ARB_IDLE;
                grant_d      = '0;
                last_grant_d = LAST_GRANT_RST;
            end
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef ARB_PKT_CNT_EN
    logic [31:0] cnt_q [NUM_PORTS];

    // Per-port completed-packet counters, wrapping naturally at 2^32.
    always_ff @(posedge asclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pop_s[i] & in_last[i]) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt_out
        assign pkt_cnt[p*32 +: 32] = cnt_q[p];
    end
`endif

endmodule

// File: tb/tb_ingress_port_arbiter.sv
// Directed self-checking bench for ingress_port_arbiter. The bench models
// the ingress FIFOs as queues and a simple parser that pulls one length
// entry per packet and data on fifo_rd_en.
module tb_ingress_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int LW = 16;
    localparam int SW = 8;

    logic              asclk = 1'b0;
    logic              aresetn;
    logic [NP*DW-1:0]  in_data;
    logic [NP*DW/8-1:0] in_strb;
    logic [NP-1:0]     in_last, in_empty, in_user_empty;
    logic [NP*LW-1:0]  in_len;
    logic [NP-1:0]     in_rd_en, in_user_rd_en;
    logic [DW-1:0]     tx_data;
    logic [DW/8-1:0]   tx_strb;
    logic              tx_valid, tx_last;
    logic [LW-1:0]     tx_len_data;
    logic [SW-1:0]     tx_spt_data;
    logic              fifo_empty, fifo_rd_en, tx_user_rd_en;
    logic [NP-1:0]     grant;
    logic              busy;
`ifdef ARB_PKT_CNT_EN
    logic [NP*32-1:0]  pkt_cnt;
`endif

    ingress_port_arbiter dut (
        .asclk         (asclk),
        .aresetn       (aresetn),
        .in_data       (in_data),
        .in_strb       (in_strb),
        .in_last       (in_last),
        .in_empty      (in_empty),
        .in_user_empty (in_user_empty),
        .in_len        (in_len),
        .in_rd_en      (in_rd_en),
        .in_user_rd_en (in_user_rd_en),
        .tx_data       (tx_data),
        .tx_strb       (tx_strb),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_len_data   (tx_len_data),
        .tx_spt_data   (tx_spt_data),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .tx_user_rd_en (tx_user_rd_en),
        .grant         (grant),
        .busy          (busy)
`ifdef ARB_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    always #5 asclk = ~asclk;

    // FIFO model and monitor state
    logic [63:0] dq [NP][$];
    logic        lq [NP][$];
    logic [15:0] uq [NP][$];
    logic [NP-1:0] hold;
    int          order_q[$];
    int          gap_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc, last_pop_cyc, pops_beats, viol, data_err, seq;
    logic        prev_busy, len_done;
    logic [NP-1:0] prev_grant;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_heads();
        for (int i = 0; i < NP; i++) begin
            in_empty[i]      = (dq[i].size() == 0) || hold[i];
            in_user_empty[i] = (uq[i].size() == 0);
            if (dq[i].size() > 0) begin
                in_data[i*DW +: DW] = dq[i][0];
                in_last[i]          = lq[i][0];
            end else begin
                in_data[i*DW +: DW] = 64'h0;
                in_last[i]          = 1'b0;
            end
            in_strb[i*8 +: 8] = in_last[i] ? 8'h0F : 8'hFF;
            if (uq[i].size() > 0) in_len[i*LW +: LW] = uq[i][0];
            else                  in_len[i*LW +: LW] = 16'h0;
        end
        tx_user_rd_en = busy && !len_done;
    endtask

    task automatic tick();
        logic [NP-1:0] rd_s, urd_s;
        logic          was_last;
        @(negedge asclk);
        rd_s  = in_rd_en;
        urd_s = in_user_rd_en;
        for (int i = 0; i < NP; i++) begin
            if (rd_s[i]) begin
                pops_beats++;
                if (in_empty[i] || !grant[i] || dq[i].size() == 0) viol++;
                else begin
                    if (tx_data !== dq[i][0] || tx_last !== lq[i][0] ||
                        tx_strb !== in_strb[i*8 +: 8]) data_err++;
                    if (lq[i][0]) begin
                        order_q.push_back(i);
                        last_pop_cyc = cyc;
                    end
                end
            end
            if (urd_s[i] && (in_user_empty[i] || !grant[i])) viol++;
        end
        if (busy && !prev_busy && last_pop_cyc >= 0) gap_q.push_back(cyc - last_pop_cyc - 1);
        if (busy && prev_busy && grant !== prev_grant) viol++;
        prev_busy  = busy;
        prev_grant = grant;
        @(posedge asclk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (urd_s[i] && uq[i].size() > 0) begin
                void'(uq[i].pop_front());
                len_done = 1'b1;
            end
            if (rd_s[i] && dq[i].size() > 0) begin
                was_last = lq[i][0];
                void'(dq[i].pop_front());
                void'(lq[i].pop_front());
                if (was_last) len_done = 1'b0;
            end
        end
        cyc++;
        drive_heads();
        #1;
    endtask

    task automatic load_pkt(input int p, input int nbeats, input logic [15:0] len);
        for (int b = 0; b < nbeats; b++) begin
            dq[p].push_back({8'(p), 8'(seq), 40'h0, 8'(b)});
            lq[p].push_back(b == nbeats - 1);
        end
        uq[p].push_back(len);
        seq++;
    endtask

    function automatic bit model_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (dq[i].size() != 0 || uq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic reset_dut();
        for (int i = 0; i < NP; i++) begin
            dq[i].delete();
            lq[i].delete();
            uq[i].delete();
        end
        hold       = '0;
        fifo_rd_en = 1'b0;
        len_done   = 1'b0;
        seq        = 0;
        aresetn    = 1'b0;
        drive_heads();
        tick();
        tick();
        aresetn = 1'b1;
        order_q.delete();
        gap_q.delete();
        last_pop_cyc = -1;
        pops_beats   = 0;
        viol         = 0;
        data_err     = 0;
    endtask

    task automatic run_drain(input int maxc);
        int n;
        n = 0;
        while ((!model_empty() || busy) && n < maxc) begin
            tick();
            n++;
        end
        chk_eq("drain_done", 64'(n < maxc), 64'h1);
        tick();
        tick();
    endtask

    function automatic logic [63:0] order_word();
        logic [63:0] w;
        w = 64'h0;
        for (int k = 0; k < order_q.size() && k < 16; k++) w = w | (64'(order_q[k]) << (4 * k));
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gmin, gmax;
        aresetn = 1'b0; fifo_rd_en = 1'b0; tx_user_rd_en = 1'b0;
        hold = '0; len_done = 1'b0; cyc = 0; prev_busy = 1'b0; prev_grant = '0;
        in_data = '0; in_strb = '0; in_last = '0; in_len = '0;
        in_empty = '1; in_user_empty = '1;

        // Reset state; pops requested while idle must be ignored
        reset_dut();
        fifo_rd_en = 1'b1; tx_user_rd_en = 1'b1; #1;
        chk_eq("rst_grant", 64'(grant), 64'h0);
        chk_eq("rst_busy", 64'(busy), 64'h0);
        chk_eq("rst_fifo_empty", 64'(fifo_empty), 64'h1);
        chk_eq("rst_tx_valid", 64'(tx_valid), 64'h0);
        chk_eq("rst_rd_en", 64'(in_rd_en), 64'h0);
        chk_eq("rst_user_rd_en", 64'(in_user_rd_en), 64'h0);
`ifdef ARB_PKT_CNT_EN
        chk_eq("rst_pkt_cnt_lo", pkt_cnt[63:0], 64'h0);
        chk_eq("rst_pkt_cnt_hi", pkt_cnt[127:64], 64'h0);
`endif

        // Single 3-beat packet on port 2
        reset_dut();
        load_pkt(2, 3, 16'd24);
        drive_heads(); #1;
        chk_eq("p2_grant_before", 64'(grant), 64'h0);
        tick();
        chk_eq("p2_grant", 64'(grant), 64'h4);
        chk_eq("p2_busy", 64'(busy), 64'h1);
        chk_eq("p2_spt", 64'(tx_spt_data), 64'h04);
        chk_eq("p2_len", 64'(tx_len_data), 64'd24);
        chk_eq("p2_valid", 64'(tx_valid), 64'h1);
        chk_eq("p2_fifo_empty", 64'(fifo_empty), 64'h0);
        chk_eq("p2_user_rd", 64'(in_user_rd_en), 64'h4);
        chk_eq("p2_rd_idle_parser", 64'(in_rd_en), 64'h0);
        fifo_rd_en = 1'b1; #1;
        chk_eq("p2_rd_en", 64'(in_rd_en), 64'h4);
        chk_eq("p2_data0", tx_data, 64'h0200_0000_0000_0000);
        tick(); tick(); tick();
        chk_eq("p2_gap_busy", 64'(busy), 64'h0);
        chk_eq("p2_gap_grant", 64'(grant), 64'h0);
        chk_eq("p2_gap_fifo_empty", 64'(fifo_empty), 64'h1);
        chk_eq("p2_pops", 64'(pops_beats), 64'd3);
        chk_eq("p2_len_popped", 64'(uq[2].size()), 64'd0);
        tick();
        chk_eq("p2_idle_busy", 64'(busy), 64'h0);
        chk_eq("p2_order", order_word(), 64'h2);
        chk_eq("p2_viol", 64'(viol), 64'd0);
        chk_eq("p2_data_err", 64'(data_err), 64'd0);

        // All ports, two packets each: strict round-robin with 2-cycle gaps
        reset_dut();
        for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) load_pkt(p, 2, 16'd16);
        fifo_rd_en = 1'b1; drive_heads(); #1;
        run_drain(200);
        chk_eq("rr_count", 64'(order_q.size()), 64'd8);
        chk_eq("rr_order", order_word(), 64'h3210_3210);
        gmin = 1000; gmax = -1;
        foreach (gap_q[k]) begin
            if (gap_q[k] < gmin) gmin = gap_q[k];
            if (gap_q[k] > gmax) gmax = gap_q[k];
        end
        chk_eq("rr_gap_count", 64'(gap_q.size()), 64'd7);
        chk_eq("rr_gap_min", 64'(gmin), 64'd2);
        chk_eq("rr_gap_max", 64'(gmax), 64'd2);
        chk_eq("rr_viol", 64'(viol), 64'd0);
        chk_eq("rr_data_err", 64'(data_err), 64'd0);

        // Port 0 becomes eligible while port 1 is mid-packet
        reset_dut();
        load_pkt(1, 4, 16'd32);
        fifo_rd_en = 1'b1; drive_heads(); #1;
        tick();
        chk_eq("hold_grant1", 64'(grant), 64'h2);
        tick();
        load_pkt(0, 2, 16'd16);
        drive_heads(); #1;
        tick();
        chk_eq("hold_grant_kept", 64'(grant), 64'h2);
        run_drain(100);
        chk_eq("hold_count", 64'(order_q.size()), 64'd2);
        chk_eq("hold_order", order_word(), 64'h01);
        chk_eq("hold_viol", 64'(viol), 64'd0);

        // Port 3 stalls on its last beat for 5 cycles with fifo_rd_en held
        reset_dut();
        load_pkt(3, 2, 16'd16);
        fifo_rd_en = 1'b1; drive_heads(); #1;
        tick();
        tick();
        hold[3] = 1'b1; drive_heads(); #1;
        chk_eq("stall_fifo_empty", 64'(fifo_empty), 64'h1);
        chk_eq("stall_valid", 64'(tx_valid), 64'h0);
        chk_eq("stall_rd_en", 64'(in_rd_en), 64'h0);
        repeat (5) tick();
        chk_eq("stall_grant", 64'(grant), 64'h8);
        chk_eq("stall_busy", 64'(busy), 64'h1);
        chk_eq("stall_pops", 64'(pops_beats), 64'd1);
        hold[3] = 1'b0; drive_heads(); #1;
        chk_eq("stall_resume_valid", 64'(tx_valid), 64'h1);
        run_drain(50);
        chk_eq("stall_total_pops", 64'(pops_beats), 64'd2);
        chk_eq("stall_order", order_word(), 64'h3);
        chk_eq("stall_viol", 64'(viol), 64'd0);
        chk_eq("stall_data_err", 64'(data_err), 64'd0);

        // Reset pulsed on beat 2 of 4: grant dropped, partial packet kept
        reset_dut();
        load_pkt(2, 4, 16'd32);
        load_pkt(2, 2, 16'd16);
        fifo_rd_en = 1'b1; drive_heads(); #1;
        tick();
        tick();
        tick();
        load_pkt(0, 2, 16'd16);
        aresetn = 1'b0; drive_heads(); #1;
        chk_eq("mrst_rd_en", 64'(in_rd_en), 64'h0);
        chk_eq("mrst_user_rd_en", 64'(in_user_rd_en), 64'h0);
        chk_eq("mrst_valid", 64'(tx_valid), 64'h0);
        tick();
        chk_eq("mrst_grant", 64'(grant), 64'h0);
        chk_eq("mrst_busy", 64'(busy), 64'h0);
        chk_eq("mrst_remaining", 64'(dq[2].size()), 64'd4);
        chk_eq("mrst_pops", 64'(pops_beats), 64'd2);
        aresetn = 1'b1; len_done = 1'b0; drive_heads(); #1;
        tick();
        chk_eq("mrst_first_grant", 64'(grant), 64'h1);

        // Five packets on port 1
        reset_dut();
        for (int n = 0; n < 5; n++) load_pkt(1, 2, 16'd16);
        fifo_rd_en = 1'b1; drive_heads(); #1;
        run_drain(200);
        chk_eq("cnt_pkts", 64'(order_q.size()), 64'd5);
        chk_eq("cnt_viol", 64'(viol), 64'd0);
`ifdef ARB_PKT_CNT_EN
        chk_eq("cnt_port1", 64'(pkt_cnt[63:32]), 64'd5);
        chk_eq("cnt_port0", 64'(pkt_cnt[31:0]), 64'd0);
        chk_eq("cnt_port23", pkt_cnt[127:64], 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
